// File: rtl/gpr_wbu_pkg.sv
// Shared constants for the GPR write-back unit and its register file.
package gpr_wbu_pkg;
   localparam int XLEN     = 32;
   localparam int NREG     = 32;
   localparam int RAW      = $clog2(NREG);
   localparam int ZERO_REG = 0;
endpackage

// File: rtl/gpr_wbu_if.sv
// Execute-stage result handshake into the write-back unit.
interface gpr_wbu_if #(
   parameter int XLEN = gpr_wbu_pkg::XLEN,
   parameter int AW   = gpr_wbu_pkg::RAW
);
   logic            in_valid;
   logic            in_ready;
   logic            in_wen;
   logic [AW-1:0]   in_rd;
   logic [XLEN-1:0] in_data;

   modport master (output in_valid, in_wen, in_rd, in_data, input in_ready);
   modport slave  (input in_valid, in_wen, in_rd, in_data, output in_ready);
endinterface

// File: rtl/gpr_wbu_file.sv
// General-purpose register array: one synchronous write port, two combinational
// read ports, register 0 reads as zero and is never written.
module gpr_file #(
   parameter int XLEN = gpr_wbu_pkg::XLEN,
   parameter int NREG = gpr_wbu_pkg::NREG
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [$clog2(NREG)-1:0]  waddr,
   input  logic [XLEN-1:0]          wdata,
   input  logic [$clog2(NREG)-1:0]  raddr1,
   input  logic [$clog2(NREG)-1:0]  raddr2,
   output logic [XLEN-1:0]          rdata1,
   output logic [XLEN-1:0]          rdata2
);
   import gpr_wbu_pkg::*;

   localparam int AW = $clog2(NREG);

   logic [XLEN-1:0] regs [NREG];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (we && (waddr != AW'(ZERO_REG))) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata1 = (raddr1 == AW'(ZERO_REG)) ? '0 : regs[raddr1];
   assign rdata2 = (raddr2 == AW'(ZERO_REG)) ? '0 : regs[raddr2];
endmodule

// File: rtl/gpr_wbu.sv
// Write-back unit: one-entry pending buffer between execute and the register
// file, with operand bypass from that entry, registered commit report and retire counter.
module gpr_wbu #(
   parameter int XLEN = gpr_wbu_pkg::XLEN,
   parameter int NREG = gpr_wbu_pkg::NREG
) (
   input  logic                     clk,
   input  logic                     rst,
   gpr_wbu_if.slave                 in_if,
   input  logic                     wb_stall,
   input  logic [$clog2(NREG)-1:0]  raddr1,
   input  logic [$clog2(NREG)-1:0]  raddr2,
   output logic [XLEN-1:0]          rdata1,
   output logic [XLEN-1:0]          rdata2,
   output logic                     commit,
   output logic [$clog2(NREG)-1:0]  commit_rd,
   output logic [XLEN-1:0]          commit_data,
   output logic [31:0]              retire_cnt
);
   import gpr_wbu_pkg::*;

   localparam int AW = $clog2(NREG);

   logic            pend_valid;
   logic            pend_wen;
   logic [AW-1:0]   pend_rd;
   logic [XLEN-1:0] pend_data;
   logic            xfer;
   logic            drain;
   logic [XLEN-1:0] file_rdata1;
   logic [XLEN-1:0] file_rdata2;

   assign in_if.in_ready = !pend_valid || !wb_stall;
   assign xfer           = in_if.in_valid && in_if.in_ready;
   assign drain          = pend_valid && !wb_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_valid  <= 1'b0;
         pend_wen    <= 1'b0;
         pend_rd     <= '0;
         pend_data   <= '0;
         commit      <= 1'b0;
         commit_rd   <= '0;
         commit_data <= '0;
         retire_cnt  <= '0;
      end else begin
         // A new transfer on a drain edge refills the buffer, so no bubble.
         if (xfer) begin
            pend_valid <= 1'b1;
            pend_wen   <= in_if.in_wen;
            pend_rd    <= in_if.in_rd;
            pend_data  <= in_if.in_data;
         end else if (drain) begin
            pend_valid <= 1'b0;
         end
         commit <= drain;
         if (drain) begin
            commit_rd   <= pend_rd;
            commit_data <= pend_data;
            retire_cnt  <= retire_cnt + 32'd1;
         end
      end
   end

   gpr_file #(.XLEN(XLEN), .NREG(NREG)) u_file (
      .clk    (clk),
      .rst    (rst),
      .we     (drain && pend_wen),
      .waddr  (pend_rd),
      .wdata  (pend_data),
      .raddr1 (raddr1),
      .raddr2 (raddr2),
      .rdata1 (file_rdata1),
      .rdata2 (file_rdata2)
   );

   function automatic logic [XLEN-1:0] bypass(input logic [AW-1:0] addr,
                                              input logic [XLEN-1:0] stored);
      if (addr == AW'(ZERO_REG))
         return '0;
      else if (pend_valid && pend_wen && (pend_rd == addr))
         return pend_data;
      else
         return stored;
   endfunction

   always_comb begin
      rdata1 = bypass(raddr1, file_rdata1);
      rdata2 = bypass(raddr2, file_rdata2);
   end
endmodule

// File: tb/tb_gpr_wbu.sv
// Self-checking bench for gpr_wbu: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_gpr_wbu;
   logic        clk = 1'b0;
   logic        rst;
   logic        wb_stall;
   logic [4:0]  raddr1, raddr2;
   logic [31:0] rdata1, rdata2;
   logic        commit;
   logic [4:0]  commit_rd;
   logic [31:0] commit_data;
   logic [31:0] retire_cnt;

   gpr_wbu_if #(.XLEN(32), .AW(5)) bus ();

   gpr_wbu #(.XLEN(32), .NREG(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_if       (bus),
      .wb_stall    (wb_stall),
      .raddr1      (raddr1),
      .raddr2      (raddr2),
      .rdata1      (rdata1),
      .rdata2      (rdata2),
      .commit      (commit),
      .commit_rd   (commit_rd),
      .commit_data (commit_data),
      .retire_cnt  (retire_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wen;
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t        pq[$];
   logic [31:0] m_regs [32];
   logic [31:0] m_cnt;
   logic        exp_commit;
   logic [4:0]  exp_crd;
   logic [31:0] exp_cdata;
   int          n_cmp = 0;
   int          n_err = 0;

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (pq.size() != 0 && pq[0].wen && pq[0].rd == a) return pq[0].data;
      return m_regs[a];
   endfunction

   function automatic logic m_ready();
      return (pq.size() == 0) || !wb_stall;
   endfunction

   task automatic model_reset();
      pq.delete();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_cnt = 32'd0;
      exp_commit = 1'b0;
      exp_crd = 5'd0;
      exp_cdata = 32'd0;
   endtask

   task automatic model_edge();
      logic rdy;
      ent_t e;
      rdy = m_ready();
      exp_commit = 1'b0;
      if (pq.size() != 0 && !wb_stall) begin
         e = pq.pop_front();
         if (e.wen && e.rd != 5'd0) m_regs[e.rd] = e.data;
         m_cnt = m_cnt + 32'd1;
         exp_commit = 1'b1;
         exp_crd = e.rd;
         exp_cdata = e.data;
      end
      if (bus.in_valid && rdy) begin
         e.wen = bus.in_wen;
         e.rd = bus.in_rd;
         e.data = bus.in_data;
         pq.push_back(e);
      end
   endtask

   task automatic drive(input logic v, input logic w, input logic [4:0] rd,
                        input logic [31:0] d, input logic s);
      bus.in_valid = v;
      bus.in_wen = w;
      bus.in_rd = rd;
      bus.in_data = d;
      wb_stall = s;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      raddr1 = 5'd0;
      raddr2 = 5'd0;
      model_reset();
      #3;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
      n_cmp++; if (commit !== 1'b0) begin n_err++; $display("FAIL reset_commit: got %b want 0", commit); end
      n_cmp++; if (retire_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt: got %h want 0", retire_cnt); end
      n_cmp++; if (commit_rd !== 5'd0 || commit_data !== 32'd0) begin n_err++; $display("FAIL reset_commit_fields: got %h/%h want 0/0", commit_rd, commit_data); end
      for (int i = 0; i < 32; i++) begin
         raddr1 = 5'(i);
         #0.1;
         n_cmp++; if (rdata1 !== 32'd0) begin n_err++; $display("FAIL reset_reg%0d: got %h want 0", i, rdata1); end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      raddr1 = 5'd5;
      drive(1'b1, 1'b1, 5'd5, 32'h1234_5678, 1'b0);
      #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b want 1", bus.in_ready); end
      tick();
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      #1;
      n_cmp++; if (rdata1 !== 32'h1234_5678) begin n_err++; $display("FAIL basic_bypass: got %h want 12345678", rdata1); end
      n_cmp++; if (commit !== 1'b0) begin n_err++; $display("FAIL basic_no_commit_yet: got %b want 0", commit); end
      tick();
      n_cmp++; if (commit !== 1'b1 || commit_rd !== 5'd5 || commit_data !== 32'h1234_5678) begin n_err++; $display("FAIL basic_commit: got %b/%0d/%h want 1/5/12345678", commit, commit_rd, commit_data); end
      n_cmp++; if (rdata1 !== 32'h1234_5678) begin n_err++; $display("FAIL basic_stored: got %h want 12345678", rdata1); end
      n_cmp++; if (retire_cnt !== 32'd1) begin n_err++; $display("FAIL basic_cnt: got %0d want 1", retire_cnt); end
      tick();
      n_cmp++; if (commit !== 1'b0) begin n_err++; $display("FAIL basic_commit_pulse: got %b want 0", commit); end
   endtask

   task automatic test_zero_reg();
      logic [31:0] cnt0;
      cnt0 = m_cnt;
      raddr1 = 5'd0;
      drive(1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0);
      tick();
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      #1;
      n_cmp++; if (rdata1 !== 32'd0) begin n_err++; $display("FAIL zero_pending_read: got %h want 0", rdata1); end
      tick();
      n_cmp++; if (commit !== 1'b1 || commit_rd !== 5'd0) begin n_err++; $display("FAIL zero_commit: got %b/%0d want 1/0", commit, commit_rd); end
      n_cmp++; if (rdata1 !== 32'd0) begin n_err++; $display("FAIL zero_after_read: got %h want 0", rdata1); end
      n_cmp++; if (retire_cnt !== cnt0 + 32'd1) begin n_err++; $display("FAIL zero_cnt: got %0d want %0d", retire_cnt, cnt0 + 32'd1); end
   endtask

   task automatic test_stall();
      logic [31:0] cnt0;
      int ncommit;
      raddr2 = 5'd3;
      drive(1'b1, 1'b1, 5'd3, 32'hA5A5_0303, 1'b1);
      tick();
      cnt0 = m_cnt;
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, 1'b1, 5'd3, $urandom, 1'b1);
         #1;
         n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready%0d: got %b want 0", c, bus.in_ready); end
         n_cmp++; if (rdata2 !== 32'hA5A5_0303) begin n_err++; $display("FAIL stall_bypass%0d: got %h want a5a50303", c, rdata2); end
         tick();
         n_cmp++; if (retire_cnt !== cnt0 || commit !== 1'b0) begin n_err++; $display("FAIL stall_frozen%0d: got cnt %0d commit %b want %0d/0", c, retire_cnt, commit, cnt0); end
      end
      ncommit = 0;
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
         tick();
         if (commit === 1'b1) ncommit++;
      end
      n_cmp++; if (ncommit != 1) begin n_err++; $display("FAIL stall_release_commits: got %0d want 1", ncommit); end
      n_cmp++; if (rdata2 !== 32'hA5A5_0303 || retire_cnt !== cnt0 + 32'd1) begin n_err++; $display("FAIL stall_release_state: got %h/%0d want a5a50303/%0d", rdata2, retire_cnt, cnt0 + 32'd1); end
   endtask

   task automatic test_back_to_back();
      int seen;
      seen = 0;
      for (int r = 1; r <= 9; r++) begin
         if (r <= 8) drive(1'b1, 1'b1, 5'(r), 32'(r * 32'h11), 1'b0);
         else        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
         #1;
         if (r <= 8) begin
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready%0d: got %b want 1", r, bus.in_ready); end
         end
         tick();
         if (r >= 2) begin
            n_cmp++; if (commit !== 1'b1 || commit_rd !== 5'(r - 1) || commit_data !== 32'((r - 1) * 32'h11)) begin n_err++; $display("FAIL b2b_commit%0d: got %b/%0d/%h want 1/%0d/%h", r - 1, commit, commit_rd, commit_data, r - 1, (r - 1) * 32'h11); end
            if (commit === 1'b1) seen++;
         end
      end
      tick();
      n_cmp++; if (seen != 8 || commit !== 1'b0) begin n_err++; $display("FAIL b2b_pulses: got %0d then %b want 8 then 0", seen, commit); end
      for (int r = 1; r <= 8; r++) begin
         raddr1 = 5'(r);
         #1;
         n_cmp++; if (rdata1 !== 32'(r * 32'h11)) begin n_err++; $display("FAIL b2b_reg%0d: got %h want %h", r, rdata1, r * 32'h11); end
      end
   endtask

   task automatic test_async_reset();
      raddr1 = 5'd9;
      drive(1'b1, 1'b1, 5'd9, 32'hCAFE_0009, 1'b1);
      tick();
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      #2;
      n_cmp++; if (bus.in_ready !== 1'b0 || rdata1 !== 32'hCAFE_0009) begin n_err++; $display("FAIL areset_pre: got %b/%h want 0/cafe0009", bus.in_ready, rdata1); end
      rst = 1'b1;
      model_reset();
      #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL areset_pend_cleared: got ready %b want 1", bus.in_ready); end
      n_cmp++; if (rdata1 !== 32'd0 || retire_cnt !== 32'd0 || commit !== 1'b0) begin n_err++; $display("FAIL areset_state: got %h/%0d/%b want 0/0/0", rdata1, retire_cnt, commit); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      tick();
      tick();
      n_cmp++; if (rdata1 !== 32'd0 || retire_cnt !== 32'd0 || commit !== 1'b0) begin n_err++; $display("FAIL areset_after: got %h/%0d/%b want 0/0/0", rdata1, retire_cnt, commit); end
   endtask

   task automatic test_wrap();
      drive(1'b1, 1'b1, 5'd7, 32'h0000_0777, 1'b1);
      tick();
      force dut.retire_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.retire_cnt;
      m_cnt = 32'hFFFF_FFFF;
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      #1;
      n_cmp++; if (retire_cnt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_preload: got %h want ffffffff", retire_cnt); end
      tick();
      n_cmp++; if (retire_cnt !== 32'd0 || commit !== 1'b1) begin n_err++; $display("FAIL wrap_cnt: got %h/%b want 0/1", retire_cnt, commit); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         drive(($urandom_range(0, 2) != 0), $urandom_range(0, 1), 5'($urandom_range(0, 7)),
               $urandom, ($urandom_range(0, 2) == 0));
         raddr1 = 5'($urandom_range(0, 7));
         raddr2 = 5'($urandom_range(0, 7));
         #1;
         n_cmp++; if (bus.in_ready !== m_ready()) begin n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", c, bus.in_ready, m_ready()); end
         n_cmp++; if (rdata1 !== m_read(raddr1) || rdata2 !== m_read(raddr2)) begin n_err++; $display("FAIL rnd_read c%0d: got %h/%h want %h/%h", c, rdata1, rdata2, m_read(raddr1), m_read(raddr2)); end
         tick();
         n_cmp++; if (commit !== exp_commit) begin n_err++; $display("FAIL rnd_commit c%0d: got %b want %b", c, commit, exp_commit); end
         if (exp_commit) begin
            n_cmp++; if (commit_rd !== exp_crd || commit_data !== exp_cdata) begin n_err++; $display("FAIL rnd_commit_entry c%0d: got %0d/%h want %0d/%h", c, commit_rd, commit_data, exp_crd, exp_cdata); end
         end
         n_cmp++; if (retire_cnt !== m_cnt) begin n_err++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, retire_cnt, m_cnt); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_reg();
      test_stall();
      test_back_to_back();
      test_async_reset();
      test_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/gpr_wbu.md
GPR_WBU -- requirements
Module: gpr_wbu

Interface
REQ-001 Parameter XLEN, default 32, data width of results and registers.
REQ-002 Parameter NREG, default 32, number of general-purpose registers; register address width is log2(NREG) (5 at default).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  execute stage presents a result this cycle.
REQ-006 in_ready  out  1  block accepts the presented result this cycle.
REQ-007 in_wen  in  1  result writes a register (0 = retire without write, e.g. branch/store).
REQ-008 in_rd  in  5  destination register index.
REQ-009 in_data  in  XLEN  result value from execute stage.
REQ-010 wb_stall  in  1  freezes drain of the pending entry (debug/halt).
REQ-011 raddr1, raddr2  in  5 each  operand read addresses for the execute stage.
REQ-012 rdata1, rdata2  out  XLEN each  operand read data (feeds execute-stage operand inputs).
REQ-013 commit  out  1  one-cycle pulse: an entry retired this cycle.
REQ-014 commit_rd  out  5, commit_data  out  XLEN  index/value of the retiring entry, valid when commit=1.
REQ-015 retire_cnt  out  32  count of retired entries.

Function
REQ-016 A transfer occurs on a rising edge with in_valid=1 and in_ready=1; the block SHALL latch in_wen, in_rd, in_data into a one-entry pending buffer (pend_valid, pend_wen, pend_rd, pend_data).
REQ-017 in_ready SHALL equal (!pend_valid || !wb_stall), combinationally.
REQ-018 Drain: on an edge with pend_valid=1 and wb_stall=0, the block SHALL write pend_data to register pend_rd if pend_wen=1 and pend_rd!=0, increment retire_cnt by 1, and clear pend_valid unless a new transfer occurs the same edge.
REQ-019 Simultaneous drain and transfer SHALL both take effect: the old entry retires, the new entry occupies the buffer; no bubble, throughput one per cycle.
REQ-020 commit, commit_rd, commit_data SHALL be registered: asserted the cycle after the drain edge, carrying the drained entry; commit=0 otherwise.
REQ-021 Register 0 SHALL read as 0 always and never be written, including when pend_wen=1 and pend_rd=0 (entry still retires and counts).
REQ-022 Reads are combinational; rdataN SHALL be 0 if raddrN=0, else pend_data if pend_valid && pend_wen && pend_rd==raddrN, else stored register value.
REQ-023 Bypass SHALL apply while stalled; a stalled entry remains visible through REQ-022 indefinitely.
REQ-024 retire_cnt SHALL wrap from 0xFFFFFFFF to 0 without flag.
REQ-025 in_valid=0 with pend_valid=0: no state change except commit deasserting.
REQ-026 Values on in_* when no transfer occurs SHALL be ignored.

Reset
REQ-027 While rst=1: pend_valid=0, commit=0, commit_rd=0, commit_data=0, retire_cnt=0, all registers 0; effect immediate, independent of clk.
REQ-028 Reset mid-operation SHALL discard a pending entry without writing or counting it.
REQ-029 First transfer SHALL be possible on the first rising edge after rst deasserts (in_ready=1 during and after reset).

Structure
REQ-030 A shared package SHALL hold XLEN, NREG, register-address width constant, and the zero-register index.
REQ-031 The register array SHALL be a sub-module gpr_file: NREG x XLEN, one synchronous write port, two combinational read ports, register 0 hardwired to 0, asynchronous reset clears all entries.
REQ-032 gpr_wbu SHALL contain the pending buffer, handshake, bypass mux, commit register and counter only.

Verification
REQ-033 Reset then transfer (wen=1, rd=5, data=0x12345678), no stall -> next cycle commit=1, commit_rd=5; raddr1=5 reads 0x12345678 both while pending (bypass) and after drain; retire_cnt=1.
REQ-034 Transfer rd=0, data=0xDEADBEEF, wen=1 -> raddr1=0 reads 0 throughout; commit=1, retire_cnt increments.
REQ-035 Pending entry rd=3 with wb_stall=1 for 4 cycles -> in_ready=0, retire_cnt unchanged, raddr2=3 returns bypassed value; release stall -> single commit.
REQ-036 Back-to-back transfers every cycle rd=1..8, data=rd*0x11 -> in_ready=1 each cycle, eight consecutive commit pulses in order, registers 1..8 hold 0x11..0x88.
REQ-037 Pending entry present, assert rst asynchronously mid-cycle -> pend_valid=0 immediately, target register remains 0, retire_cnt=0, no commit.
REQ-038 Force retire_cnt to 0xFFFFFFFF, retire one entry -> retire_cnt=0.
